bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 169 ++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Optional switch-driven auto trigger: define BIN2BCD_AUTO_START_EN.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam longint unsigned MAXV =
    (64'd1 << WIDTH) - 64'd1;

  function automatic longint unsigned pow10(
    input int n
  );
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Too few digits would silently truncate the top digit.
  generate
    if (pow10(DIGITS) <= MAXV) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    scratch;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             trigger;
  logic             last_step;
  logic             neg_in;
  logic [WIDTH-1:0] mag_in;
  logic [BW-1:0]    adj;
  logic [SW-1:0]    sh;
  logic [BW-1:0]    scratch_sh;
  logic [WIDTH-1:0] mag_sh;

`ifdef BIN2BCD_AUTO_START_EN
  logic [WIDTH:0]   seen;
  logic             primed;

  // Remember the switch setting of the last accepted conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen   <= '0;
      primed <= 1'b0;
    end else if (state == IDLE && trigger) begin
      seen   <= {is_signed, value};
      primed <= 1'b1;
    end
  end

  // Any switch change (or first use after reset) starts a conversion.
  always_comb begin
    trigger = start
            | ~primed
            | ({is_signed, value} != seen);
  end
`else
  // Conversions only on explicit request.
  always_comb begin
    trigger = start;
  end
`endif

  // Sign split: magnitude of a two's complement input fits WIDTH bits.
  always_comb begin
    neg_in = is_signed & value[WIDTH-1];
    mag_in = value;
    if (neg_in) mag_in = ~value + WIDTH'(1);
  end

  // One double-dabble step: add 3 to digits >= 5, then shift left.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    sh         = {adj, mag} << 1;
    scratch_sh = sh[SW-1:WIDTH];
    mag_sh     = sh[WIDTH-1:0];
    last_step  = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) state_nxt = CONVERT;
      end
      CONVERT: begin
        busy = 1'b1;
        if (last_step) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate, publish on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag      <= '0;
      scratch  <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            neg     <= neg_in;
            mag     <= mag_in;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        CONVERT: begin
          scratch <= scratch_sh;
          mag     <= mag_sh;
          cnt     <= cnt + CW'(1);
          if (last_step) begin
            bcd      <= scratch_sh;
            negative <= neg;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed scoreboard bench for bin_to_bcd_seq (default build).
// Expected results come from an arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  value;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        negative;

  int total = 0;
  int bad   = 0;

  logic [16:0] sb[$];
  logic [16:0] cur_exp;
  logic [15:0] prev_bcd;

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(
    input logic [9:0] v,
    input logic       s
  );
    int   m;
    logic n;
    logic [15:0] d;
    n = s & v[9];
    m = n ? (1024 - int'(v)) : int'(v);
    d[3:0]   = 4'(m % 10);
    d[7:4]   = 4'((m / 10) % 10);
    d[11:8]  = 4'((m / 100) % 10);
    d[15:12] = 4'((m / 1000) % 10);
    return {n, d};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Result checker: every done pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("bcd", 32'(bcd), 32'(e[15:0]));
        chk("negative", 32'(negative), 32'(e[16]));
      end
    end
  end

  // Drive a start for one cycle; returns in cycle T+1.
  task automatic start_conv(
    input logic [9:0] v,
    input logic       s,
    input bit         push
  );
    value     = v;
    is_signed = s;
    start     = 1'b1;
    if (push) begin
      cur_exp = model(v, s);
      sb.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Check n busy cycles with outputs holding.
  task automatic busy_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("done_low", 32'(done), 32'd0);
      chk("bcd_hold", 32'(bcd), 32'(prev_bcd));
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic expect_done();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    prev_bcd = cur_exp[15:0];
  endtask

  task automatic full_conv(
    input logic [9:0] v,
    input logic       s
  );
    start_conv(v, s, 1'b1);
    busy_cycles(10);
    expect_done();
    @(posedge clk);
    #1;
    chk("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    value     = '0;
    is_signed = 1'b0;
    prev_bcd  = '0;
    cur_exp   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_neg", 32'(negative), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    full_conv(10'd10, 1'b0);
    full_conv(10'b1111110110, 1'b1);
    full_conv(10'b1111110110, 1'b0);
    full_conv(10'h3FF, 1'b0);
    full_conv(10'b1000000000, 1'b1);
    full_conv(10'd0, 1'b1);
    full_conv(10'd0, 1'b0);
    full_conv(10'h3FF, 1'b1);
    full_conv(10'h1FF, 1'b1);

    // Start while busy is ignored; start in done cycle is accepted.
    start_conv(10'd10, 1'b0, 1'b1);
    busy_cycles(2);
    value = 10'd999;
    start = 1'b1;
    busy_cycles(8);
    expect_done();
    start_conv(10'd999, 1'b0, 1'b1);
    value = 10'd5;
    is_signed = 1'b1;
    busy_cycles(10);
    expect_done();
    @(posedge clk);
    #1;

    // Reset aborts a conversion with no done.
    start_conv(10'd1023, 1'b0, 1'b0);
    busy_cycles(4);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    prev_bcd = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_neg", 32'(negative), 32'd0);
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("abort_idle", 32'(busy), 32'd0);
    end
    full_conv(10'd42, 1'b1);
    full_conv(10'd987, 1'b0);

    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
